a51_stream_combiner: RTL and testbench
======================================

Name: a51_stream_combiner

Overview:
- Consumer end of the A5/1 keystream: takes the serial keystream bits produced during the output stage and XORs them, MSB-first, with the 224-bit message held in the data store.
- Packs the resulting ciphertext/plaintext into bytes and hands them downstream (display/PS2-side logic) over a valid/ready interface.
- Buffers bytes in a small FIFO, because the keystream cannot be stalled.
- The operation is symmetric: the same block encrypts and decrypts.

Parameters:
- MSG_BITS, 224, message length in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, output byte width.
- FIFO_DEPTH, 4, number of output byte buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start  input  1  single-cycle pulse; latches msg_in and arms the combiner.
- msg_in  input  MSG_BITS  message from the data store; bit MSG_BITS-1 is consumed first.
- ks_bit  input  1  keystream bit (a51out).
- ks_valid  input  1  ks_bit is valid this cycle; asserted by the A5/1 output stage.
- out_byte  output  BYTE_W  FIFO head byte; first combined bit is in the MSB.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out_byte.
- busy  output  1  high in COLLECT or DRAIN.
- done  output  1  one-cycle pulse when the frame is fully delivered.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset values (while reset=0): state=IDLE, message shift register=0, bit counter=0, byte accumulator=0, FIFO empty. Outputs out_byte=0, out_valid=0, busy=0, done=0, overflow=0.
- Reset asserted mid-frame aborts the frame immediately; no partial byte is emitted.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - start=1 loads msg_in into the shift register, clears the bit counter, accumulator and overflow, then moves to COLLECT.
  - ks_valid is ignored in IDLE.
- COLLECT, on each cycle with ks_valid=1:
  - r = shift[MSG_BITS-1] ^ ks_bit.
  - accumulator = {accumulator[BYTE_W-2:0], r}.
  - shift register shifts left by one, filling with 0.
  - bit counter increments.
  - Cycles with ks_valid=0 hold all state; gaps are allowed.
- Byte completion (bit counter mod BYTE_W reaches BYTE_W-1 while accepting a bit):
  - The completed byte, {accumulator[BYTE_W-2:0], r}, is pushed into the FIFO on that same edge.
  - out_valid rises the following cycle (1-cycle latency from the 8th bit).
  - Accumulator bit positions reset for the next byte.
- FIFO push/pop:
  - Pop occurs when out_valid & out_ready.
  - If a push arrives with the FIFO full and no pop in that cycle: byte dropped, overflow set and held until the next start or reset.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: the byte is stored and out_valid rises the next cycle. No bypass.
- COLLECT to DRAIN: after the MSG_BITS-th accepted bit (counter = MSG_BITS-1 while accepting). Width: counter is clog2(MSG_BITS) bits and never wraps.
- DRAIN:
  - ks_valid is ignored.
  - When the FIFO is empty, move to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. The FIFO is empty at this point.
- start outside IDLE is ignored. No re-latch, no counter change.
- busy = (state==COLLECT) or (state==DRAIN).
- Total bytes delivered per frame = MSG_BITS/BYTE_W (28) minus dropped bytes.

Test Plan:
- Zero message: msg_in=0, start, then 224 cycles of ks_valid=1 with ks_bit=1, out_ready=1 → 28 bytes of 0xFF in order, overflow=0, done pulses once, busy falls the same cycle done rises.
- Identity keystream: msg_in=0xA5 repeated, ks_bit=0 throughout → output 0xA5 ×28.
  - Then feed that output back as msg_in with keystream 0x3C pattern, and again with the same pattern → second pass restores 0xA5 ×28 (encrypt/decrypt symmetry).
- Backpressure: out_ready=0 throughout COLLECT → first 4 bytes held, 5th byte completion sets overflow=1, bytes 5–28 dropped.
  - Then raise out_ready → exactly 4 bytes delivered, then done.
- Gapped keystream: ks_valid toggling 1/0 every cycle, msg_in=0x0102…1C → bytes equal msg bytes XOR keystream bytes, unaffected by gaps, and the first byte appears 1 cycle after its 8th valid bit.
- Control edges:
  - start pulsed again mid-COLLECT with a different msg_in → ignored; output matches the first message.
  - reset low after 100 bits → all outputs 0 at once; a following start runs a clean full frame.

Source files
------------

// File: rtl/a51_stream_combiner_if.sv
// Handshake bundle between the A5/1 keystream combiner and its producer/consumer.
// The master drives start/msg/keystream and accepts output bytes; the combiner is the slave.
interface a51_stream_combiner_if #(
  parameter int unsigned MSG_BITS = 224,
  parameter int unsigned BYTE_W   = 8
);
  logic                start;
  logic [MSG_BITS-1:0] msg_in;
  logic                ks_bit;
  logic                ks_valid;
  logic [BYTE_W-1:0]   out_byte;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;
  logic                overflow;

  modport master (
    output start, msg_in, ks_bit, ks_valid, out_ready,
    input  out_byte, out_valid, busy, done, overflow
  );

  modport slave (
    input  start, msg_in, ks_bit, ks_valid, out_ready,
    output out_byte, out_valid, busy, done, overflow
  );
endinterface

// File: rtl/a51_stream_combiner.sv
// XORs the serial A5/1 keystream with a latched message (MSB first), packs the result
// into bytes and buffers them in a small FIFO because the keystream cannot be stalled.
module a51_stream_combiner #(
  parameter int unsigned MSG_BITS   = 224,
  parameter int unsigned BYTE_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  a51_stream_combiner_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(MSG_BITS);
  localparam int unsigned BPOS_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_n;
  logic [MSG_BITS-1:0] shift;
  logic [CNT_W-1:0]    bit_cnt;
  logic [BPOS_W-1:0]   bpos;
  logic [BYTE_W-2:0]   acc;
  logic [BYTE_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [LVL_W-1:0]    level_n;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;
  logic                overflow_q;

  logic                start_c;
  logic                accept_c;
  logic                r_c;
  logic [BYTE_W-1:0]   byte_c;
  logic                byte_done_c;
  logic                last_bit_c;
  logic                pop_c;
  logic                full_c;
  logic                wr_en_c;

  assign start_c     = (state == S_IDLE) && bus.start;
  assign accept_c    = (state == S_COLLECT) && bus.ks_valid;
  assign r_c         = shift[MSG_BITS-1] ^ bus.ks_bit;
  assign byte_c      = {acc, r_c};
  assign byte_done_c = accept_c && (bpos == BPOS_W'(BYTE_W - 1));
  assign last_bit_c  = accept_c && (bit_cnt == CNT_W'(MSG_BITS - 1));
  assign pop_c       = valid_q && bus.out_ready;
  assign full_c      = (level == LVL_W'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_en_c     = byte_done_c && (!full_c || pop_c);
  assign level_n     = level + LVL_W'(wr_en_c) - LVL_W'(pop_c);

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (bus.start) state_n = S_COLLECT;
      S_COLLECT: if (last_bit_c) state_n = S_DRAIN;
      S_DRAIN:   if (level == '0) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  // State register with registered status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == S_COLLECT) || (state_n == S_DRAIN);
      done_q <= (state_n == S_DONE);
    end
  end

  // Message shift register, bit counters and byte accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift      <= '0;
      bit_cnt    <= '0;
      bpos       <= '0;
      acc        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (start_c) begin
        shift   <= bus.msg_in;
        bit_cnt <= '0;
        bpos    <= '0;
        acc     <= '0;
      end else if (accept_c) begin
        shift   <= {shift[MSG_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_W'(1);
        bpos    <= byte_done_c ? '0 : bpos + BPOS_W'(1);
        acc     <= byte_done_c ? '0 : byte_c[BYTE_W-2:0];
      end
      if (start_c) begin
        overflow_q <= 1'b0;
      end else if (byte_done_c && full_c && !pop_c) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Output byte FIFO; no bypass, so a fresh byte is visible one cycle after its push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= byte_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      level   <= level_n;
      valid_q <= (level_n != '0);
    end
  end

  assign bus.out_byte  = mem[rd_ptr];
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_a51_stream_combiner.sv
// Randomized bench for a51_stream_combiner against a queue-based frame model.
module tb_a51_stream_combiner;
  localparam int unsigned MSG_BITS   = 224;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          NBYTES     = MSG_BITS / BYTE_W;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  a51_stream_combiner_if #(.MSG_BITS(MSG_BITS), .BYTE_W(BYTE_W)) bus ();

  a51_stream_combiner #(
    .MSG_BITS(MSG_BITS), .BYTE_W(BYTE_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                  m_state;
  logic [MSG_BITS-1:0] m_msg;
  int                  m_bits;
  logic [7:0]          m_cur;
  logic [7:0]          q[$];
  bit                  m_ovf;
  int                  m_dropped;

  logic [MSG_BITS-1:0] ks_arr;
  logic [7:0]          got[$];
  int                  done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [MSG_BITS-1:0] msg, input int i);
    logic [MSG_BITS-1:0] x;
    x = msg ^ ks_arr;
    return x[MSG_BITS-1-8*i -: 8];
  endfunction

  function automatic logic [MSG_BITS-1:0] rand_msg();
    logic [MSG_BITS-1:0] m;
    for (int i = 0; i < 7; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [MSG_BITS-1:0] pack_got();
    logic [MSG_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < NBYTES && i < got.size(); i++) m[MSG_BITS-1-8*i -: 8] = got[i];
    return m;
  endfunction

  // One clock edge of the behavioural frame model
  task automatic model_edge(input bit st, input bit kv, input bit kb, input bit rdy,
                            input logic [MSG_BITS-1:0] mi);
    bit pop;
    bit have_push;
    bit r;
    logic [7:0] pb;
    pop = (q.size() > 0) && rdy;
    have_push = 1'b0;
    pb = '0;
    case (m_state)
      M_IDLE: if (st) begin
        m_msg = mi; m_bits = 0; m_cur = '0; m_ovf = 1'b0; m_dropped = 0;
        m_state = M_COLLECT;
      end
      M_COLLECT: if (kv) begin
        r = m_msg[MSG_BITS-1-m_bits] ^ kb;
        m_cur = {m_cur[6:0], r};
        m_bits++;
        if (m_bits % BYTE_W == 0) begin have_push = 1'b1; pb = m_cur; end
        if (m_bits == MSG_BITS) m_state = M_DRAIN;
      end
      M_DRAIN: if (q.size() == 0) m_state = M_DONE;
      default: m_state = M_IDLE;
    endcase
    if (pop) void'(q.pop_front());
    if (have_push) begin
      if (q.size() < FIFO_DEPTH) q.push_back(pb);
      else begin m_ovf = 1'b1; m_dropped++; end
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk({ph, "_byte"}, 32'(bus.out_byte), 32'(q[0]));
    chk({ph, "_busy"}, 32'(bus.busy), 32'(m_state == M_COLLECT || m_state == M_DRAIN));
    chk({ph, "_done"}, 32'(bus.done), 32'(m_state == M_DONE));
    chk({ph, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic cycle(input bit st, input logic [MSG_BITS-1:0] mi, input bit kv,
                       input bit kb, input bit rdy);
    @(negedge clk);
    bus.start = st; bus.msg_in = mi; bus.ks_valid = kv; bus.ks_bit = kb; bus.out_ready = rdy;
    if (bus.out_valid && rdy) got.push_back(bus.out_byte);
    model_edge(st, kv, kb, rdy, mi);
    @(posedge clk);
    #1;
    check_outputs("cyc");
    if (bus.done) done_seen++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0; bus.ks_valid = 1'b0; bus.ks_bit = 1'b0; bus.out_ready = 1'b0;
    m_state = M_IDLE; q.delete(); m_ovf = 1'b0; m_bits = 0; m_cur = '0; m_dropped = 0;
    #1;
    chk({tag, "_rst_byte"}, 32'(bus.out_byte), 32'h0);
    chk({tag, "_rst_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, "_rst_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_rst_done"}, 32'(bus.done), 32'h0);
    chk({tag, "_rst_ovf"}, 32'(bus.overflow), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // vmode: 0 always valid, 1 alternate, 2 random; rmode: 0 ready, 1 stalled in COLLECT, 2 random
  task automatic run_frame(input logic [MSG_BITS-1:0] msg, input int vmode, input int rmode,
                           input int reset_at, input bit mid_start);
    int k;
    int cyc;
    bit kv, kb, rdy, st;
    k = 0; cyc = 0;
    got.delete(); done_seen = 0;
    cycle(1'b1, msg, 1'b0, 1'b0, 1'b1);
    while (m_state != M_IDLE && cyc < 4000) begin
      case (vmode)
        0:       kv = 1'b1;
        1:       kv = (cyc % 2 == 0);
        default: kv = 1'($urandom_range(0, 1));
      endcase
      kb = (k < int'(MSG_BITS)) ? ks_arr[MSG_BITS-1-k] : 1'($urandom);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (m_state != M_COLLECT);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      st = mid_start && (k == 40);
      if (reset_at >= 0 && k == reset_at && m_state == M_COLLECT) begin
        do_reset("mid");
        return;
      end
      if (m_state == M_COLLECT && kv) k++;
      cycle(st, ~msg, kv, kb, rdy);
      cyc++;
    end
    chk("frame_end", 32'(m_state), 32'(M_IDLE));
    chk("done_pulses", 32'(done_seen), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input logic [MSG_BITS-1:0] msg, input int n);
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) chk({tag, "_data"}, 32'(got[i]), 32'(ref_byte(msg, i)));
  endtask

  initial begin
    logic [MSG_BITS-1:0] m1, m2;
    bus.start = 1'b0; bus.msg_in = '0; bus.ks_valid = 1'b0; bus.ks_bit = 1'b0; bus.out_ready = 1'b0;
    m_state = M_IDLE; m_msg = '0; m_bits = 0; m_cur = '0; m_ovf = 1'b0; m_dropped = 0;
    ks_arr = '0; done_seen = 0;
    do_reset("por");

    // Zero message with all-ones keystream gives 0xFF bytes
    ks_arr = '1;
    run_frame('0, 0, 0, -1, 1'b0);
    chk("zero_count", 32'(got.size()), 32'(NBYTES));
    foreach (got[i]) chk("zero_byte", 32'(got[i]), 32'hFF);
    chk("zero_ovf", 32'(bus.overflow), 32'h0);

    // Identity keystream, then encrypt/decrypt symmetry
    m1 = {NBYTES{8'hA5}};
    ks_arr = '0;
    run_frame(m1, 0, 0, -1, 1'b0);
    foreach (got[i]) chk("ident_byte", 32'(got[i]), 32'hA5);
    m2 = pack_got();
    ks_arr = {NBYTES{8'h3C}};
    run_frame(m2, 0, 0, -1, 1'b0);
    foreach (got[i]) chk("enc_byte", 32'(got[i]), 32'h99);
    m2 = pack_got();
    run_frame(m2, 0, 0, -1, 1'b0);
    chk("dec_count", 32'(got.size()), 32'(NBYTES));
    foreach (got[i]) chk("dec_byte", 32'(got[i]), 32'hA5);

    // Backpressure: only the first FIFO_DEPTH bytes survive
    m1 = rand_msg(); ks_arr = rand_msg();
    run_frame(m1, 0, 1, -1, 1'b0);
    check_bytes("bp", m1, int'(FIFO_DEPTH));
    chk("bp_ovf", 32'(bus.overflow), 32'h1);

    // Gapped keystream over 0x01..0x1C
    for (int i = 0; i < NBYTES; i++) m1[MSG_BITS-1-8*i -: 8] = 8'(i + 1);
    ks_arr = rand_msg();
    run_frame(m1, 1, 0, -1, 1'b0);
    check_bytes("gap", m1, NBYTES);
    chk("gap_ovf_clr", 32'(bus.overflow), 32'h0);

    // Restart mid-frame is ignored
    m1 = rand_msg(); ks_arr = rand_msg();
    run_frame(m1, 0, 0, -1, 1'b1);
    check_bytes("midstart", m1, NBYTES);

    // Reset after 100 bits, then a clean frame
    run_frame(m1, 0, 0, 100, 1'b0);
    m1 = rand_msg(); ks_arr = rand_msg();
    run_frame(m1, 2, 0, -1, 1'b0);
    check_bytes("postrst", m1, NBYTES);

    // Random valid/ready frames
    for (int f = 0; f < 4; f++) begin
      m1 = rand_msg(); ks_arr = rand_msg();
      run_frame(m1, 2, 2, -1, 1'b0);
      chk("rand_count", 32'(got.size()), 32'(NBYTES - m_dropped));
      if (m_dropped == 0) check_bytes("rand", m1, NBYTES);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
